// File: rtl/frac_strobe_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : frac_strobe_gen_if
//  Purpose  : Bundles the control, configuration and status signals of the
//             fractional strobe generator.
//  Ports    : master - config/status side (drives en, load, divisors, mode,
//                      burst_len; observes strobe, busy, done, cfg_err,
//                      remaining)
//             slave  - the generator itself (mirror of master)
//  Revision : 1.0 - initial release
// ============================================================================
interface frac_strobe_gen_if #(
    parameter int N = 16,
    parameter int F = 8,
    parameter int B = 8
);
    logic         en;
    logic         load;
    logic [N-1:0] div_int;
    logic [F-1:0] div_frac;
    logic         mode;
    logic [B-1:0] burst_len;
    logic         strobe;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic [B-1:0] remaining;

    modport master (
        output en, load, div_int, div_frac, mode, burst_len,
        input  strobe, busy, done, cfg_err, remaining
    );

    modport slave (
        input  en, load, div_int, div_frac, mode, burst_len,
        output strobe, busy, done, cfg_err, remaining
    );
endinterface
`default_nettype wire

// File: rtl/frac_strobe_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frac_strobe_gen
//  Purpose  : One-cycle strobe generator with average period
//             div_int + div_frac/2^F cycles (first-order accumulation),
//             continuous or fixed-length burst operation, run/abort control
//             and reconfiguration that only takes effect at period
//             boundaries.
//  Ports    : clk - system clock (rising edge)
//             rst - synchronous active-high reset
//             sb  - slave side of frac_strobe_gen_if (control in, status out)
//  Revision : 1.0 - initial release
// ============================================================================
module frac_strobe_gen #(
    parameter int N = 16,
    parameter int F = 8,
    parameter int B = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    frac_strobe_gen_if.slave    sb
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [F-1:0] acc_q, acc_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [B-1:0] rem_q, rem_d;
    logic         strobe_q, strobe_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         armed_q, armed_d;

    // Active configuration (governs the current period)
    logic [N-1:0] act_int_q, act_int_d;
    logic [F-1:0] act_frac_q, act_frac_d;
    logic         act_mode_q, act_mode_d;
    logic [B-1:0] act_blen_q, act_blen_d;

    // Shadow configuration captured by a load while running
    logic [N-1:0] sh_int_q, sh_int_d;
    logic [F-1:0] sh_frac_q, sh_frac_d;
    logic         sh_mode_q, sh_mode_d;
    logic [B-1:0] sh_blen_q, sh_blen_d;
    logic         pend_q, pend_d;

    // Configuration that becomes active at this edge if applied. A load in
    // the same cycle wins over an older pending shadow.
    logic [N-1:0] w_nxt_int;
    logic [F-1:0] w_nxt_frac;
    logic         w_nxt_mode;
    logic [B-1:0] w_nxt_blen;

    assign w_nxt_int  = sb.load ? sb.div_int   : (pend_q ? sh_int_q  : act_int_q);
    assign w_nxt_frac = sb.load ? sb.div_frac  : (pend_q ? sh_frac_q : act_frac_q);
    assign w_nxt_mode = sb.load ? sb.mode      : (pend_q ? sh_mode_q : act_mode_q);
    assign w_nxt_blen = sb.load ? sb.burst_len : (pend_q ? sh_blen_q : act_blen_q);

    // Period computation. The first period after IDLE uses the config that
    // was active before this edge; a boundary period uses the newly applied one.
    logic [N-1:0] w_per_int;
    logic [F-1:0] w_per_frac;
    logic         w_clamp;
    logic [N-1:0] w_eff_int;
    logic [F:0]   w_sum;
    logic [N-1:0] w_cnt_load;

    assign w_per_int  = (state_q == IDLE) ? act_int_q  : w_nxt_int;
    assign w_per_frac = (state_q == IDLE) ? act_frac_q : w_nxt_frac;
    assign w_clamp    = (w_per_int < N'(2));
    assign w_eff_int  = w_clamp ? N'(2) : w_per_int;
    assign w_sum      = {1'b0, acc_q} + {1'b0, w_per_frac};
    // P - 1 = eff + carry - 1; cannot overflow since eff >= 2
    assign w_cnt_load = w_eff_int - N'(1) + {{(N-1){1'b0}}, w_sum[F]};

    logic w_apply;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        armed_d   = armed_q;
        sh_int_d  = sh_int_q;
        sh_frac_d = sh_frac_q;
        sh_mode_d = sh_mode_q;
        sh_blen_d = sh_blen_q;
        w_apply   = 1'b0;

        // A new burst needs en to have been observed low since the last one
        if (!sb.en) begin
            armed_d = 1'b1;
        end

        if (sb.load) begin
            sh_int_d  = sb.div_int;
            sh_frac_d = sb.div_frac;
            sh_mode_d = sb.mode;
            sh_blen_d = sb.burst_len;
        end

        case (state_q)
            IDLE: begin
                // In IDLE a load goes straight to the active config
                w_apply = 1'b1;
                if (sb.en && armed_q) begin
                    state_d = RUN;
                    acc_d   = w_sum[F-1:0];
                    cnt_d   = w_cnt_load;
                    err_d   = err_q | w_clamp;
                    rem_d   = act_mode_q ? act_blen_q : '0;
                end
            end
            RUN: begin
                if (!sb.en) begin
                    // Abort: silent return, pending config applied on entry
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    w_apply = 1'b1;
                end else if (act_mode_q && (rem_q == '0)) begin
                    // Zero-length burst completes without any strobe
                    done_d  = 1'b1;
                    state_d = IDLE;
                    armed_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    w_apply = 1'b1;
                end else if (cnt_q == '0) begin
                    strobe_d = 1'b1;
                    w_apply  = 1'b1;
                    if (act_mode_q && (rem_q == B'(1))) begin
                        done_d  = 1'b1;
                        rem_d   = '0;
                        state_d = IDLE;
                        armed_d = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = w_sum[F-1:0];
                        cnt_d = w_cnt_load;
                        err_d = err_q | w_clamp;
                        if (!w_nxt_mode) begin
                            rem_d = '0;
                        end else if (act_mode_q) begin
                            rem_d = rem_q - B'(1);
                        end else begin
                            rem_d = w_nxt_blen;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - N'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_apply) begin
            act_int_d  = w_nxt_int;
            act_frac_d = w_nxt_frac;
            act_mode_d = w_nxt_mode;
            act_blen_d = w_nxt_blen;
            pend_d     = 1'b0;
        end else begin
            act_int_d  = act_int_q;
            act_frac_d = act_frac_q;
            act_mode_d = act_mode_q;
            act_blen_d = act_blen_q;
            pend_d     = pend_q | sb.load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b1;
            act_int_q  <= N'(2);
            act_frac_q <= '0;
            act_mode_q <= 1'b0;
            act_blen_q <= '0;
            sh_int_q   <= N'(2);
            sh_frac_q  <= '0;
            sh_mode_q  <= 1'b0;
            sh_blen_q  <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            armed_q    <= armed_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            act_mode_q <= act_mode_d;
            act_blen_q <= act_blen_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            sh_mode_q  <= sh_mode_d;
            sh_blen_q  <= sh_blen_d;
            pend_q     <= pend_d;
        end
    end

    assign sb.strobe    = strobe_q;
    assign sb.busy      = (state_q == RUN);
    assign sb.done      = done_q;
    assign sb.cfg_err   = err_q;
    assign sb.remaining = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_strobe_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frac_strobe_gen
//  Purpose  : Directed, table-driven bench for frac_strobe_gen. Offsets are
//             counted in clock edges from the edge E0 that samples en=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frac_strobe_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frac_strobe_gen_if #(.N(16), .F(8), .B(8)) bus ();

    frac_strobe_gen #(.N(16), .F(8), .B(8)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] di, input logic [7:0] df,
                       input logic md, input logic [7:0] bl);
        bus.div_int   = di;
        bus.div_frac  = df;
        bus.mode      = md;
        bus.burst_len = bl;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] di;
        logic [7:0]  df;
        logic        md;
        logic [7:0]  bl;
        int          s0, s1, s2, s3;   // first four strobe offsets (-1 = none)
        int          nstr;             // strobes within the 40-cycle window
        int          done_at;          // first done offset (-1 = none)
        logic        err;
        logic        busy_end;
    } vec_t;

    localparam int NV = 8;
    localparam int W  = 40;
    vec_t vecs [NV];

    initial begin
        int t[4];
        int nst, done_t, consec, rem_bad, first_s;
        logic prev;

        vecs[0] = '{16'd4, 8'h00, 1'b0, 8'd0,  4,  8, 12, 16, 10, -1, 1'b0, 1'b1};
        vecs[1] = '{16'd4, 8'h80, 1'b0, 8'd0,  4,  9, 13, 18,  9, -1, 1'b0, 1'b1};
        vecs[2] = '{16'd3, 8'h00, 1'b1, 8'd3,  3,  6,  9, -1,  3,  9, 1'b0, 1'b0};
        vecs[3] = '{16'd1, 8'h00, 1'b0, 8'd0,  2,  4,  6,  8, 20, -1, 1'b1, 1'b1};
        vecs[4] = '{16'd0, 8'h00, 1'b0, 8'd0,  2,  4,  6,  8, 20, -1, 1'b1, 1'b1};
        vecs[5] = '{16'd2, 8'h00, 1'b1, 8'd0, -1, -1, -1, -1,  0,  1, 1'b0, 1'b0};
        vecs[6] = '{16'd5, 8'h40, 1'b0, 8'd0,  5, 10, 15, 21,  7, -1, 1'b0, 1'b1};
        vecs[7] = '{16'd2, 8'hFF, 1'b1, 8'd4,  2,  5,  8, 11,  4, 11, 1'b0, 1'b0};

        bus.div_int = '0; bus.div_frac = '0; bus.mode = 1'b0; bus.burst_len = '0;

        // Reset state
        do_reset();
        check("reset strobe",    32'(bus.strobe),    0);
        check("reset busy",      32'(bus.busy),      0);
        check("reset done",      32'(bus.done),      0);
        check("reset cfg_err",   32'(bus.cfg_err),   0);
        check("reset remaining", 32'(bus.remaining), 0);

        // Table-driven runs
        for (int v = 0; v < NV; v++) begin
            do_reset();
            cfg(vecs[v].di, vecs[v].df, vecs[v].md, vecs[v].bl);
            bus.en = 1'b1;
            tick();                                   // E0
            check($sformatf("v%0d busy at E0", v), 32'(bus.busy), 1);
            for (int i = 0; i < 4; i++) t[i] = -1;
            nst = 0; done_t = -1; consec = 0; rem_bad = 0; prev = 1'b0;
            for (int k = 1; k <= W; k++) begin
                tick();
                if (bus.strobe) begin
                    if (nst < 4) t[nst] = k;
                    nst++;
                    if (prev) consec++;
                end
                prev = bus.strobe;
                if (bus.done && done_t < 0) done_t = k;
                if (!vecs[v].md && bus.remaining != '0) rem_bad++;
            end
            check($sformatf("v%0d strobe0", v), t[0], vecs[v].s0);
            check($sformatf("v%0d strobe1", v), t[1], vecs[v].s1);
            check($sformatf("v%0d strobe2", v), t[2], vecs[v].s2);
            check($sformatf("v%0d strobe3", v), t[3], vecs[v].s3);
            check($sformatf("v%0d strobe count", v), nst, vecs[v].nstr);
            check($sformatf("v%0d done offset", v), done_t, vecs[v].done_at);
            check($sformatf("v%0d back-to-back strobes", v), consec, 0);
            check($sformatf("v%0d continuous remaining", v), rem_bad, 0);
            check($sformatf("v%0d cfg_err", v), 32'(bus.cfg_err), 32'(vecs[v].err));
            check($sformatf("v%0d busy at end", v), 32'(bus.busy), 32'(vecs[v].busy_end));
            bus.en = 1'b0;
        end

        // Reconfiguration: mid-period load, then a load on a boundary cycle
        do_reset();
        cfg(16'd5, 8'h00, 1'b0, 8'd0);
        bus.en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) t[i] = -1;
        nst = 0; first_s = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.strobe) begin
                if (nst < 4) t[nst] = k;
                else if (nst == 4) first_s = k;
                nst++;
            end
            bus.load    = (k == 2) || (k == 20);
            bus.div_int = (k == 2) ? 16'd8 : 16'd3;
        end
        bus.load = 1'b0;
        check("reload strobe0", t[0], 5);
        check("reload strobe1", t[1], 13);
        check("reload strobe2", t[2], 21);
        check("reload strobe3", t[3], 24);
        check("reload strobe4", first_s, 27);

        // Abort 2 cycles into a 6-cycle period with a pending load
        do_reset();
        cfg(16'd6, 8'h00, 1'b0, 8'd0);
        bus.en = 1'b1;
        tick();
        tick();
        bus.div_int = 16'd3; bus.load = 1'b1;   // pending, sampled at edge 2
        tick();
        bus.load = 1'b0;
        bus.en   = 1'b0;                         // abort sampled at edge 3
        tick();
        check("abort busy",   32'(bus.busy),   0);
        check("abort strobe", 32'(bus.strobe), 0);
        check("abort done",   32'(bus.done),   0);
        nst = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.strobe || bus.done) nst++;
        end
        check("abort quiet", nst, 0);
        bus.en = 1'b1;
        tick();                                   // new E0, pending div 3 now active
        first_s = -1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.strobe && first_s < 0) first_s = k;
        end
        check("abort pending applied", first_s, 3);
        bus.en = 1'b0;

        // Burst: remaining count, no restart while en high, restart after en low
        do_reset();
        cfg(16'd3, 8'h00, 1'b1, 8'd3);
        bus.en = 1'b1;
        tick();
        check("burst remaining start", 32'(bus.remaining), 3);
        repeat (3) tick();
        check("burst strobe1",    32'(bus.strobe),    1);
        check("burst remaining1", 32'(bus.remaining), 2);
        repeat (6) tick();
        check("burst last strobe", 32'(bus.strobe),    1);
        check("burst done",        32'(bus.done),      1);
        check("burst remaining0",  32'(bus.remaining), 0);
        check("burst busy off",    32'(bus.busy),      0);
        nst = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.strobe || bus.busy) nst++;
        end
        check("burst no restart", nst, 0);
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
        check("burst restart busy", 32'(bus.busy), 1);
        repeat (3) tick();
        check("burst restart strobe", 32'(bus.strobe), 1);
        bus.en = 1'b0;

        // Reset on the edge where a strobe would be registered
        do_reset();
        cfg(16'd1, 8'h00, 1'b0, 8'd0);
        bus.en = 1'b1;
        tick();
        repeat (3) tick();
        check("clamp cfg_err sticky", 32'(bus.cfg_err), 1);
        rst = 1'b1;                               // edge 4 would strobe
        tick();
        rst = 1'b0;
        bus.en = 1'b0;
        check("rst strobe",    32'(bus.strobe),    0);
        check("rst busy",      32'(bus.busy),      0);
        check("rst done",      32'(bus.done),      0);
        check("rst cfg_err",   32'(bus.cfg_err),   0);
        check("rst remaining", 32'(bus.remaining), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
